// File: rtl/log_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | log_mem_ctrl : burst sample logger into a single-port RAM with readback.   |
// | Optional macro LOG_DECIM_EN keeps 1 of every DECIM_FACTOR valid samples.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module log_mem_ctrl #(
  parameter int NB_ADDR_MEM  = 15,
  parameter int NB_DATA      = 32,
  parameter int DECIM_FACTOR = 4
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_run_log,
  input  logic                   i_read_log,
  input  logic [NB_ADDR_MEM-1:0] i_addr_log,
  input  logic [NB_DATA-1:0]     i_data,
  input  logic                   i_valid,
  output logic [NB_DATA-1:0]     o_data_log,
  output logic                   o_mem_full,
  output logic                   o_logging,
  output logic [NB_ADDR_MEM:0]   o_log_cnt
);

  localparam int                     c_depth     = 2**NB_ADDR_MEM;
  localparam logic [NB_ADDR_MEM-1:0] c_last_addr = '1;
  localparam logic [NB_ADDR_MEM:0]   c_full_cnt  = {1'b1, {NB_ADDR_MEM{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOGGING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_run_d;
  logic [NB_ADDR_MEM-1:0]  r_wr_addr;
  logic [NB_DATA-1:0]      r_ram [c_depth];

  logic                    w_run_rise;
  logic                    w_valid_log;
  logic                    w_decim_ok;
  logic                    w_accept;
  logic                    w_rd_en;
  logic [NB_ADDR_MEM-1:0]  w_wr_addr;

  assign w_run_rise  = i_run_log & ~r_run_d;
  assign w_valid_log = i_valid & (r_state == ST_LOGGING);
  assign w_accept    = w_valid_log & w_decim_ok & i_rst;
  assign w_rd_en     = i_read_log & (r_state != ST_LOGGING);
  // A restart that coincides with a valid sample lands that sample at address 0.
  assign w_wr_addr   = w_run_rise ? '0 : r_wr_addr;

`ifdef LOG_DECIM_EN
  localparam int                   c_decim_w    = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
  localparam logic [c_decim_w-1:0] c_decim_last = c_decim_w'(DECIM_FACTOR - 1);

  logic [c_decim_w-1:0] r_decim_cnt;
  logic [c_decim_w-1:0] w_decim_base;
  logic [c_decim_w-1:0] w_decim_next;

  always_comb begin
    w_decim_base = w_run_rise ? '0 : r_decim_cnt;
    w_decim_ok   = (w_decim_base == '0);
    w_decim_next = w_decim_base;
    if (w_valid_log) begin
      w_decim_next = (w_decim_base == c_decim_last) ? '0 : w_decim_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_decim_cnt <= '0;
    end else begin
      r_decim_cnt <= w_decim_next;
    end
  end
`else
  localparam int c_unused_decim = DECIM_FACTOR;
  assign w_decim_ok = 1'b1;
`endif

  // RAM array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ram[w_wr_addr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_run_d    <= 1'b0;
      r_wr_addr  <= '0;
      o_data_log <= '0;
      o_mem_full <= 1'b0;
      o_logging  <= 1'b0;
      o_log_cnt  <= '0;
    end else begin
      r_run_d <= i_run_log;
      if (w_rd_en) begin
        o_data_log <= r_ram[i_addr_log];
      end
      case (r_state)
        ST_LOGGING: begin
          if (w_accept) begin
            r_wr_addr <= w_wr_addr + 1'b1;
            if (w_wr_addr == c_last_addr) begin
              r_state    <= ST_FULL;
              o_logging  <= 1'b0;
              o_mem_full <= 1'b1;
              o_log_cnt  <= c_full_cnt;
            end else begin
              o_log_cnt <= {1'b0, w_wr_addr} + 1'b1;
            end
          end else if (w_run_rise) begin
            r_wr_addr <= '0;
            o_log_cnt <= '0;
          end
        end
        ST_IDLE, ST_FULL: begin
          if (w_run_rise) begin
            r_state    <= ST_LOGGING;
            o_logging  <= 1'b1;
            r_wr_addr  <= '0;
            o_log_cnt  <= '0;
            o_mem_full <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          o_logging <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_log_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_log_mem_ctrl : directed self-checking bench for log_mem_ctrl (16 words).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_log_mem_ctrl;

  localparam int c_aw = 4;

  logic            clk;
  logic            i_rst;
  logic            i_run_log;
  logic            i_read_log;
  logic [c_aw-1:0] i_addr_log;
  logic [31:0]     i_data;
  logic            i_valid;
  logic [31:0]     o_data_log;
  logic            o_mem_full;
  logic            o_logging;
  logic [c_aw:0]   o_log_cnt;

  int n_total = 0;
  int n_bad   = 0;

  log_mem_ctrl #(
    .NB_ADDR_MEM (c_aw),
    .NB_DATA     (32),
    .DECIM_FACTOR(4)
  ) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_run_log (i_run_log),
    .i_read_log(i_read_log),
    .i_addr_log(i_addr_log),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_data_log(o_data_log),
    .o_mem_full(o_mem_full),
    .o_logging (o_logging),
    .o_log_cnt (o_log_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs are stable and inputs change at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic read_back(input logic [31:0] base, input int step);
    for (int a = 0; a < 16; a++) begin
      i_read_log = 1'b1;
      i_addr_log = c_aw'(a);
      tick();
      check($sformatf("rd%0d", a), o_data_log, base + 32'(a * step));
    end
    i_read_log = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0; i_run_log = 1'b1; i_read_log = 1'b0;
    i_addr_log = '0; i_data = '0; i_valid = 1'b0;
    tick();
    tick();
    check("rst_full", 32'(o_mem_full), 32'd0);
    check("rst_logging", 32'(o_logging), 32'd0);
    check("rst_cnt", 32'(o_log_cnt), 32'd0);
    check("rst_data", o_data_log, 32'd0);
    i_rst = 1'b1; i_run_log = 1'b0;
    tick();

`ifdef LOG_DECIM_EN
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0; i_valid = 1'b1;
    check("dec_logging", 32'(o_logging), 32'd1);
    for (int c = 0; c < 61; c++) begin
      i_data = 32'(c);
      tick();
      if (c == 59) check("dec_not_full", 32'(o_mem_full), 32'd0);
    end
    i_valid = 1'b0;
    check("dec_full", 32'(o_mem_full), 32'd1);
    check("dec_cnt", 32'(o_log_cnt), 32'd16);
    read_back(32'd0, 4);
`else
    // Full capture with continuous valid.
    i_run_log = 1'b1; i_valid = 1'b1; i_data = 32'h0;
    tick();
    i_run_log = 1'b0;
    for (int n = 0; n < 16; n++) begin
      check("cap_logging", 32'(o_logging), 32'd1);
      check("cap_cnt", 32'(o_log_cnt), 32'(n));
      i_data = 32'h100 + 32'(n);
      tick();
    end
    i_valid = 1'b0;
    check("cap_full", 32'(o_mem_full), 32'd1);
    check("cap_logging_end", 32'(o_logging), 32'd0);
    check("cap_cnt_end", 32'(o_log_cnt), 32'd16);
    read_back(32'h100, 1);

    // Gapped valid with reads held on during the capture.
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      i_valid    = ((c - 1) % 3 == 0);
      i_data     = 32'h200 + 32'((c - 1) / 3);
      i_read_log = 1'b1;
      i_addr_log = 4'd3;
      tick();
      if (c == 45) check("gap_not_full", 32'(o_mem_full), 32'd0);
      if (c == 10) check("gap_rd_blocked", o_data_log, 32'h10F);
    end
    i_valid = 1'b0;
    check("gap_full", 32'(o_mem_full), 32'd1);
    check("gap_cnt", 32'(o_log_cnt), 32'd16);
    check("gap_rd_last_blocked", o_data_log, 32'h10F);
    tick();
    check("gap_rd_after_full", o_data_log, 32'h203);
    i_read_log = 1'b0;
    read_back(32'h200, 1);

    // Restart mid-capture with a coinciding sample.
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0; i_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      i_data = 32'h300 + 32'(n);
      tick();
    end
    check("rs_cnt5", 32'(o_log_cnt), 32'd5);
    i_run_log = 1'b1; i_data = 32'hAA;
    tick();
    check("rs_cnt1", 32'(o_log_cnt), 32'd1);
    check("rs_logging", 32'(o_logging), 32'd1);
    i_run_log = 1'b0; i_valid = 1'b0;
    tick();
    check("rs_cnt_hold", 32'(o_log_cnt), 32'd1);
    i_valid = 1'b1;
    for (int n = 0; n < 15; n++) begin
      i_data = 32'h400 + 32'(n);
      tick();
    end
    i_valid = 1'b0;
    check("rs_full", 32'(o_mem_full), 32'd1);
    i_read_log = 1'b1; i_addr_log = 4'd0;
    tick();
    check("rs_ram0", o_data_log, 32'hAA);
    i_addr_log = 4'd1;
    tick();
    check("rs_ram1", o_data_log, 32'h400);
    i_addr_log = 4'd15;
    tick();
    check("rs_ram15", o_data_log, 32'h40E);
    i_read_log = 1'b0;

    // Restart from FULL drops the full flag.
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    check("ff_full_drop", 32'(o_mem_full), 32'd0);
    check("ff_logging", 32'(o_logging), 32'd1);
    check("ff_cnt", 32'(o_log_cnt), 32'd0);
`endif

    // Reset during a capture.
    i_valid = 1'b1; i_data = 32'h55;
    tick();
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1; i_valid = 1'b0;
    check("mr_logging", 32'(o_logging), 32'd0);
    check("mr_cnt", 32'(o_log_cnt), 32'd0);
    check("mr_full", 32'(o_mem_full), 32'd0);
    check("mr_data", o_data_log, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
